seq_detect_param: RTL

Parametrised serial bit-pattern detector with a match counter. It samples a qualified 1-bit input stream, compares the most recent PAT_LEN accepted bits against a compile-time pattern, and emits a one-cycle match pulse. Overlapping or non-overlapping detection is selected at run time. It is the generalised successor to the fixed 4-bit sequence detector and sits between the serial input front end and the status/interrupt logic.

---
 rtl/seq_detect_param_if.sv | 23 ++
 rtl/seq_detect_param.sv | 104 ++++++++++
 2 files changed

// File: rtl/seq_detect_param_if.sv
// Bit-stream and match-status bundle for seq_detect_param.
// The master drives the stream and controls; the slave (detector) returns the status.
interface seq_detect_param_if #(
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic             in;
  logic             overlap;
  logic             clr_cnt;
  logic             out;
  logic [CNT_W-1:0] counter;
  logic             cnt_sat;

  modport master (
    output in_valid, in, overlap, clr_cnt,
    input  out, counter, cnt_sat
  );

  modport slave (
    input  in_valid, in, overlap, clr_cnt,
    output out, counter, cnt_sat
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with match counter and overlap select.
// Optional feature: define SEQ_DET_SAT_EN for a saturating counter with sticky cnt_sat.
module seq_detect_param #(
  parameter int unsigned          PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
  parameter int unsigned          CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_param_if.slave bus
);

  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_LEN-1:0] shifted_c;
  logic [FILL_W-1:0]  fill_inc_c;
  logic               match_c;

  // Candidate history/fill as if the current bit is accepted.
  always_comb begin
    shifted_c  = {hist_q[PAT_LEN-2:0], bus.in};
    fill_inc_c = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    match_c    = bus.in_valid && (fill_inc_c == FILL_FULL) && (shifted_c == PATTERN);
  end

  // History, fill and match-pulse next state.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = match_c;
    if (bus.in_valid) begin
      hist_d = shifted_c;
      fill_d = (match_c && !bus.overlap) ? '0 : fill_inc_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef SEQ_DET_SAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic sat_q, sat_d;

  // Saturating counter; the match that would overflow sets the sticky flag instead.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (bus.clr_cnt) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (match_c) begin
      if (cnt_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign bus.cnt_sat = sat_q;
`else
  // Wrapping counter; clear wins over a simultaneous match.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_cnt) begin
      cnt_d = '0;
    end else if (match_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign bus.cnt_sat = 1'b0;
`endif

  assign bus.out     = out_q;
  assign bus.counter = cnt_q;

endmodule
